// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared constants and types for the program-counter sequencer.
//   PC_WIDTH     : default program-counter width in bits
//   OFFSET_WIDTH : default relative-branch offset width in bits
//   RAS_DEPTH    : default return-address-stack depth in entries
//   op_t         : the operation selected for the current cycle
// ---------------------------------------------------------------------------
package pc_pkg;

    localparam int PC_WIDTH     = 10;
    localparam int OFFSET_WIDTH = 8;
    localparam int RAS_DEPTH    = 4;

    // One operation is chosen per cycle; the listing order matches decode priority.
    typedef enum logic [2:0] {
        OP_HOLD   = 3'd0,
        OP_RET    = 3'd1,
        OP_CALL   = 3'd2,
        OP_JUMP   = 3'd3,
        OP_BRANCH = 3'd4,
        OP_INC    = 3'd5
    } op_t;

endpackage

// File: rtl/pc_seq_ras.sv
// ---------------------------------------------------------------------------
// ras
// Return-address stack built as a circular buffer. Pushing while full
// overwrites the oldest entry, so the most recent RD return addresses are kept.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset (pointer and depth only)
//   push      : write push_data as the new top entry
//   pop       : discard the top entry
//   push_data : return address to store
//   top       : most recently pushed entry
//   depth     : number of valid entries, saturates at RD
//   full      : depth == RD
//   empty     : depth == 0
// ---------------------------------------------------------------------------
module ras #(
    parameter int D  = 10,
    parameter int RD = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [D-1:0]               push_data,
    output logic [D-1:0]               top,
    output logic [$clog2(RD+1)-1:0]    depth,
    output logic                       full,
    output logic                       empty
);

    localparam int DW = $clog2(RD + 1);
    localparam int PW = (RD > 1) ? $clog2(RD) : 1;

    logic [D-1:0]  mem [RD];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] ptr_prev;

    // ptr always names the slot the next push will use; the slot just
    // behind it holds the top of stack. Wrapping is explicit so RD need
    // not be a power of two.
    always_comb begin
        ptr_next = (ptr == PW'(RD - 1)) ? '0 : ptr + PW'(1);
        ptr_prev = (ptr == '0) ? PW'(RD - 1) : ptr - PW'(1);
    end

    assign top   = mem[ptr_prev];
    assign full  = (depth == DW'(RD));
    assign empty = (depth == '0);

    // Pointer and depth bookkeeping. A push while full still advances the
    // pointer, which lands the new entry on the oldest slot; depth stays at RD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            depth <= '0;
        end else if (pop) begin
            ptr   <= ptr_prev;
            depth <= depth - DW'(1);
        end else if (push) begin
            ptr <= ptr_next;
            if (!full) begin
                depth <= depth + DW'(1);
            end
        end
    end

    // Entry storage carries no reset; entries are only visible while depth > 0.
    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_seq.sv
// ---------------------------------------------------------------------------
// pc_seq
// Program-counter sequencer with jump, relative branch, call/return through
// a small return-address stack, and sticky stack-error flags.
//   clk            : clock, rising edge
//   reset          : asynchronous active-low reset
//   stall          : freeze all state this cycle
//   jumpEn         : absolute jump to target
//   branchEn       : relative branch by signed offset
//   callEn         : push PC+1 and jump to target
//   retEn          : pop return address into PC
//   errClr         : clear sticky overflow/underflow
//   target         : jump/call destination
//   offset         : signed branch displacement
//   programCounter : current PC (registered)
//   stackDepth     : valid return-stack entries
//   overflow       : sticky, call while stack full
//   underflow      : sticky, return while stack empty
// ---------------------------------------------------------------------------
module pc_seq
    import pc_pkg::*;
#(
    parameter int D  = PC_WIDTH,
    parameter int OW = OFFSET_WIDTH,
    parameter int RD = RAS_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    jumpEn,
    input  logic                    branchEn,
    input  logic                    callEn,
    input  logic                    retEn,
    input  logic                    errClr,
    input  logic [D-1:0]            target,
    input  logic [OW-1:0]           offset,
    output logic [D-1:0]            programCounter,
    output logic [$clog2(RD+1)-1:0] stackDepth,
    output logic                    overflow,
    output logic                    underflow
);

    op_t                 op;
    logic [D-1:0]        pc_inc;
    logic [D-1:0]        pc_branch;
    logic [D-1:0]        next_pc;
    logic [D-1:0]        ras_top;
    logic signed [D-1:0] offset_ext;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_full;
    logic                ras_empty;
    logic                set_overflow;
    logic                set_underflow;

    // Size-casting a signed value sign-extends it; the D-bit sums then wrap
    // naturally modulo 2^D.
    assign offset_ext = D'($signed(offset));
    assign pc_inc     = programCounter + D'(1);
    assign pc_branch  = programCounter + offset_ext;

    // Priority decode: the first enable found wins and the rest are ignored.
    always_comb begin
        op = OP_INC;
        if (stall) begin
            op = OP_HOLD;
        end else if (retEn) begin
            op = OP_RET;
        end else if (callEn) begin
            op = OP_CALL;
        end else if (jumpEn) begin
            op = OP_JUMP;
        end else if (branchEn) begin
            op = OP_BRANCH;
        end
    end

    // Next-PC selection and stack control. A return on an empty stack
    // degrades to a plain increment and only raises underflow.
    always_comb begin
        next_pc = pc_inc;
        case (op)
            OP_HOLD:   next_pc = programCounter;
            OP_RET:    next_pc = ras_empty ? pc_inc : ras_top;
            OP_CALL:   next_pc = target;
            OP_JUMP:   next_pc = target;
            OP_BRANCH: next_pc = pc_branch;
            default:   next_pc = pc_inc;
        endcase
        ras_push      = (op == OP_CALL);
        ras_pop       = (op == OP_RET) && !ras_empty;
        set_overflow  = (op == OP_CALL) && ras_full;
        set_underflow = (op == OP_RET) && ras_empty;
    end

    // PC and sticky flags. A clear in the same cycle as a fresh error leaves
    // the flag set, and a stall ignores the clear entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            programCounter <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
        end else if (op != OP_HOLD) begin
            programCounter <= next_pc;
            overflow       <= (overflow & ~errClr) | set_overflow;
            underflow      <= (underflow & ~errClr) | set_underflow;
        end
    end

    ras #(
        .D  (D),
        .RD (RD)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .depth     (stackDepth),
        .full      (ras_full),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_pc_seq.sv
// ---------------------------------------------------------------------------
// tb_pc_seq
// Self-checking bench for pc_seq with D=10, OW=8, RD=4. A queue-based model
// tracks the expected PC, stack and flags; every falling edge compares the
// DUT against it, and directed steps pin hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_seq;

    logic       clk;
    logic       reset;
    logic       stall;
    logic       jumpEn;
    logic       branchEn;
    logic       callEn;
    logic       retEn;
    logic       errClr;
    logic [9:0] target;
    logic [7:0] offset;
    logic [9:0] programCounter;
    logic [2:0] stackDepth;
    logic       overflow;
    logic       underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Control word layout: {stall, ret, call, jump, branch, errClr}
    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b100000;
    localparam logic [5:0] C_RET   = 6'b010000;
    localparam logic [5:0] C_CALL  = 6'b001000;
    localparam logic [5:0] C_JUMP  = 6'b000100;
    localparam logic [5:0] C_BR    = 6'b000010;
    localparam logic [5:0] C_CLR   = 6'b000001;

    pc_seq dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .jumpEn         (jumpEn),
        .branchEn       (branchEn),
        .callEn         (callEn),
        .retEn          (retEn),
        .errClr         (errClr),
        .target         (target),
        .offset         (offset),
        .programCounter (programCounter),
        .stackDepth     (stackDepth),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of return addresses, oldest at the front.
    int m_pc = 0;
    int m_stack[$];
    bit m_of = 1'b0;
    bit m_uf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc = 0;
            m_stack.delete();
            m_of = 1'b0;
            m_uf = 1'b0;
        end else if (!stall) begin
            if (errClr) begin
                m_of = 1'b0;
                m_uf = 1'b0;
            end
            if (retEn) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc = (m_pc + 1) % 1024;
                    m_uf = 1'b1;
                end
            end else if (callEn) begin
                if (m_stack.size() == 4) begin
                    void'(m_stack.pop_front());
                    m_of = 1'b1;
                end
                m_stack.push_back((m_pc + 1) % 1024);
                m_pc = int'(target);
            end else if (jumpEn) begin
                m_pc = int'(target);
            end else if (branchEn) begin
                m_pc = (m_pc + int'($signed(offset)) + 1024) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("model_pc", 32'(programCounter), 32'(m_pc));
        checkOutput("model_depth", 32'(stackDepth), 32'(m_stack.size()));
        checkOutput("model_overflow", 32'(overflow), 32'(m_of));
        checkOutput("model_underflow", 32'(underflow), 32'(m_uf));
    end

    task automatic applyStimulus(input logic [5:0] ctl, input logic [9:0] t,
                                 input logic [7:0] o);
        {stall, retEn, callEn, jumpEn, branchEn, errClr} = ctl;
        target = t;
        offset = o;
        @(posedge clk);
        #1;
        {stall, retEn, callEn, jumpEn, branchEn, errClr} = C_IDLE;
        target = '0;
        offset = '0;
    endtask

    initial begin
        reset = 1'b0;
        {stall, retEn, callEn, jumpEn, branchEn, errClr} = C_IDLE;
        target = '0;
        offset = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_pc", 32'(programCounter), 32'd0);
        checkOutput("reset_depth", 32'(stackDepth), 32'd0);
        checkOutput("reset_flags", 32'({overflow, underflow}), 32'd0);
        #2 reset = 1'b1;
        applyStimulus(C_IDLE, 10'd0, 8'd0);
        checkOutput("release_inc", 32'(programCounter), 32'd1);

        // Build PC=0x123, depth=2, overflow=1, then drop reset between edges
        for (int i = 0; i < 5; i++) applyStimulus(C_CALL, 10'h050, 8'd0);
        checkOutput("fill_overflow", 32'(overflow), 32'd1);
        applyStimulus(C_RET, 10'd0, 8'd0);
        applyStimulus(C_RET, 10'd0, 8'd0);
        applyStimulus(C_JUMP, 10'h123, 8'd0);
        checkOutput("pre_reset_pc", 32'(programCounter), 32'h123);
        checkOutput("pre_reset_depth", 32'(stackDepth), 32'd2);
        checkOutput("pre_reset_of", 32'(overflow), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_pc", 32'(programCounter), 32'd0);
        checkOutput("async_depth", 32'(stackDepth), 32'd0);
        checkOutput("async_flags", 32'({overflow, underflow}), 32'd0);
        #2 reset = 1'b1;
        applyStimulus(C_IDLE, 10'd0, 8'd0);
        checkOutput("rerelease_inc", 32'(programCounter), 32'd1);

        // Wrap and signed branch
        applyStimulus(C_JUMP, 10'd1023, 8'd0);
        checkOutput("jump_1023", 32'(programCounter), 32'd1023);
        applyStimulus(C_IDLE, 10'd0, 8'd0);
        checkOutput("wrap_to_0", 32'(programCounter), 32'd0);
        applyStimulus(C_JUMP, 10'd2, 8'd0);
        applyStimulus(C_BR, 10'd0, 8'hFC);
        checkOutput("branch_neg", 32'(programCounter), 32'd1022);
        applyStimulus(C_BR, 10'd0, 8'h05);
        checkOutput("branch_pos_wrap", 32'(programCounter), 32'd3);

        // Single call/return
        applyStimulus(C_JUMP, 10'd5, 8'd0);
        applyStimulus(C_CALL, 10'd100, 8'd0);
        checkOutput("call_pc", 32'(programCounter), 32'd100);
        checkOutput("call_depth", 32'(stackDepth), 32'd1);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("ret_pc", 32'(programCounter), 32'd6);
        checkOutput("ret_depth", 32'(stackDepth), 32'd0);

        // Overflow then drain and underflow
        applyStimulus(C_JUMP, 10'd10, 8'd0);
        for (int i = 2; i <= 6; i++) applyStimulus(C_CALL, 10'(i * 10), 8'd0);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_depth", 32'(stackDepth), 32'd4);
        checkOutput("ovf_pc", 32'(programCounter), 32'd60);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("pop_51", 32'(programCounter), 32'd51);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("pop_41", 32'(programCounter), 32'd41);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("pop_31", 32'(programCounter), 32'd31);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("pop_21", 32'(programCounter), 32'd21);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("udf_flag", 32'(underflow), 32'd1);
        checkOutput("udf_pc", 32'(programCounter), 32'd22);
        checkOutput("udf_depth", 32'(stackDepth), 32'd0);

        // Stall freezes everything, including the clear
        applyStimulus(C_STALL | C_CALL | C_JUMP | C_CLR, 10'd500, 8'd0);
        checkOutput("stall_pc", 32'(programCounter), 32'd22);
        checkOutput("stall_depth", 32'(stackDepth), 32'd0);
        checkOutput("stall_flags", 32'({overflow, underflow}), 32'b11);
        applyStimulus(C_CLR, 10'd0, 8'd0);
        checkOutput("clr_flags", 32'({overflow, underflow}), 32'd0);
        checkOutput("clr_pc", 32'(programCounter), 32'd23);

        // Return beats call and jump
        applyStimulus(C_CALL, 10'd200, 8'd0);
        checkOutput("prio_setup_depth", 32'(stackDepth), 32'd1);
        applyStimulus(C_RET | C_CALL | C_JUMP, 10'd300, 8'd0);
        checkOutput("prio_pc", 32'(programCounter), 32'd24);
        checkOutput("prio_depth", 32'(stackDepth), 32'd0);
        applyStimulus(C_RET, 10'd0, 8'd0);
        checkOutput("prio_nopush_uf", 32'(underflow), 32'd1);
        checkOutput("prio_nopush_pc", 32'(programCounter), 32'd25);

        // Clear coinciding with a new underflow keeps the flag
        applyStimulus(C_RET | C_CLR, 10'd0, 8'd0);
        checkOutput("clr_vs_set_uf", 32'(underflow), 32'd1);
        checkOutput("clr_vs_set_pc", 32'(programCounter), 32'd26);

        repeat (2) applyStimulus(C_IDLE, 10'd0, 8'd0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter D, default 10: program-counter width in bits.
REQ-002 SHALL have parameter OW, default 8: relative-branch offset width in bits, two's complement, OW <= D.
REQ-003 SHALL have parameter RD, default 4: return-address-stack depth in entries, RD >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  freezes all state this cycle.
REQ-007 SHALL have port jumpEn  input  1  absolute jump to target.
REQ-008 SHALL have port branchEn  input  1  relative branch by offset.
REQ-009 SHALL have port callEn  input  1  push return address, then jump to target.
REQ-010 SHALL have port retEn  input  1  pop return address into PC.
REQ-011 SHALL have port errClr  input  1  clears the sticky error flags.
REQ-012 SHALL have port target  input  D  absolute destination for jump and call.
REQ-013 SHALL have port offset  input  OW  signed branch displacement.
REQ-014 SHALL have port programCounter  output  D  current PC.
REQ-015 SHALL have port stackDepth  output  $clog2(RD+1)  number of valid stack entries.
REQ-016 SHALL have port overflow  output  1  sticky; set by a call while the stack is full.
REQ-017 SHALL have port underflow  output  1  sticky; set by a return while the stack is empty.

Function
REQ-018 SHALL decode one operation per cycle, in priority order: stall, ret, call, jump, branch, increment.
REQ-019 SHALL, on stall, hold the PC, stack, depth and flags; errClr is ignored.
REQ-020 SHALL, on increment, set next PC = PC+1 mod 2^D (1023 wraps to 0).
REQ-021 SHALL, on branch, set next PC = PC + sign-extended offset, mod 2^D.
REQ-022 SHALL, on jump, set next PC = target.
REQ-023 SHALL, on call, push (PC+1) mod 2^D, set next PC = target, and increment depth, saturating at RD.
REQ-024 SHALL, on a call with depth == RD, overwrite the oldest entry (circular buffer), keep depth at RD and set overflow.
REQ-025 SHALL, on ret with depth > 0, set next PC = most recently pushed entry and decrement depth.
REQ-026 SHALL, on ret with depth == 0, increment PC as normal, leave the stack unchanged and set underflow.
REQ-027 SHALL make every operation take effect at the next rising edge (single-cycle latency); programCounter is a register output.
REQ-028 SHALL, when errClr and a new error condition occur in the same cycle, leave the flag set.
REQ-029 SHALL silently ignore lower-priority enables asserted together with a higher-priority one.

Reset
REQ-030 SHALL, while reset is low, asynchronously drive programCounter=0, stackDepth=0, overflow=0 and underflow=0, with the stack pointer at 0.
REQ-031 SHALL not reset stack entry contents; entries are unobservable while depth is 0.
REQ-032 SHALL, on reset assertion mid-operation, abandon any in-flight call/ret with no partial update visible after release.
REQ-033 SHALL, on reset release, resume with an increment at the first rising edge.

Structure
REQ-034 SHALL take default D/OW/RD constants and the operation enum (OP_HOLD, OP_RET, OP_CALL, OP_JUMP, OP_BRANCH, OP_INC) from shared package pc_pkg.
REQ-035 SHALL implement the return stack as sub-module ras (push, pop, top, depth, full, empty), parameterised by D and RD.
REQ-036 SHALL keep priority decode and next-PC arithmetic in pc_seq.

Verification (D=10, OW=8, RD=4)
REQ-037 SHALL test: PC=0x123, depth=2, overflow=1; drop reset between edges -> all outputs 0 immediately; after release, PC=1 at the first edge.
REQ-038 SHALL test: PC=1023, no enables -> PC=0; at PC=2, branchEn with offset=8'hFC -> PC=1022.
REQ-039 SHALL test: at PC=5, callEn with target=100 -> PC=100, depth=1; then retEn -> PC=6, depth=0.
REQ-040 SHALL test: calls at PCs 10,20,30,40,50 -> overflow=1, depth=4; four rets -> PCs 51,41,31,21; fifth ret -> underflow=1, PC increments.
REQ-041 SHALL test: stall with callEn, jumpEn and errClr high -> PC, depth and flags unchanged; next cycle, errClr alone -> flags 0.
REQ-042 SHALL test: retEn, callEn and jumpEn together with depth=1 -> ret wins; PC=popped value, depth=0, no push.
